// File: rtl/data_bram_arbiter.sv
// Two-requester (comms, compute core) arbiter for a single-port BRAM with
// bounded-burst fairness and an owner-tagged read-return pipeline.
module data_bram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8,
    localparam int CNT_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  comms_req_in,
    input  logic                  comms_we_in,
    input  logic [ADDR_WIDTH-1:0] comms_addr_in,
    input  logic [DATA_WIDTH-1:0] comms_data_in,
    output logic                  comms_grant_out,
    output logic                  comms_rvalid_out,
    output logic [DATA_WIDTH-1:0] comms_rdata_out,
    input  logic                  core_req_in,
    input  logic                  core_we_in,
    input  logic [ADDR_WIDTH-1:0] core_addr_in,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    output logic                  core_grant_out,
    output logic                  core_rvalid_out,
    output logic [DATA_WIDTH-1:0] core_rdata_out,
    output logic                  bram_en_out,
    output logic                  bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_data_out,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic [1:0]            dbg_state_out,
    output logic [CNT_W-1:0]      dbg_cnt_out
);

    // Handshake: a requester holds req/we/addr/data stable until it sees its
    // grant; an access is accepted on the rising edge ending a cycle with req && grant.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COMMS = 2'd1,
        ST_CORE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_core;
    logic               comms_win;
    logic               core_win;
    logic               rd_v0;
    logic               rd_core0;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_core;

    always_comb begin
        comms_win = 1'b0;
        core_win  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (comms_req_in && core_req_in) begin
                    comms_win = last_core;
                    core_win  = !last_core;
                end else begin
                    comms_win = comms_req_in;
                    core_win  = core_req_in;
                end
            end
            ST_COMMS: begin
                if (comms_req_in && (!core_req_in || cnt < MAX_CNT)) comms_win = 1'b1;
                else                                                  core_win  = core_req_in;
            end
            ST_CORE: begin
                if (core_req_in && (!comms_req_in || cnt < MAX_CNT)) core_win  = 1'b1;
                else                                                  comms_win = comms_req_in;
            end
            default: ;
        endcase
    end

    // Grants are forced low while reset is asserted, even with requests pending.
    assign comms_grant_out = comms_win & rst_in;
    assign core_grant_out  = core_win & rst_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_core <= 1'b1;
        end else if (comms_win) begin
            last_core <= 1'b0;
            state     <= ST_COMMS;
            if (state != ST_COMMS)  cnt <= ONE_CNT;
            else if (cnt != MAX_CNT) cnt <= cnt + ONE_CNT;
        end else if (core_win) begin
            last_core <= 1'b1;
            state     <= ST_CORE;
            if (state != ST_CORE)   cnt <= ONE_CNT;
            else if (cnt != MAX_CNT) cnt <= cnt + ONE_CNT;
        end else begin
            state <= ST_IDLE;
            cnt   <= '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bram_en_out   <= 1'b0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_data_out <= '0;
            rd_v0         <= 1'b0;
            rd_core0      <= 1'b0;
            pipe_v        <= '0;
            pipe_core     <= '0;
        end else begin
            bram_en_out <= comms_win | core_win;
            bram_we_out <= (comms_win & comms_we_in) | (core_win & core_we_in);
            rd_v0       <= (comms_win & !comms_we_in) | (core_win & !core_we_in);
            rd_core0    <= core_win;
            if (comms_win) begin
                bram_addr_out <= comms_addr_in;
                bram_data_out <= comms_data_in;
            end else if (core_win) begin
                bram_addr_out <= core_addr_in;
                bram_data_out <= core_data_in;
            end
            // Read tags ride alongside the BRAM latency so returns keep issue order.
            pipe_v[0]    <= rd_v0;
            pipe_core[0] <= rd_core0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_core[i] <= pipe_core[i-1];
            end
        end
    end

    assign comms_rvalid_out = pipe_v[READ_LATENCY-1] & ~pipe_core[READ_LATENCY-1];
    assign core_rvalid_out  = pipe_v[READ_LATENCY-1] &  pipe_core[READ_LATENCY-1];
    assign comms_rdata_out  = bram_data_in;
    assign core_rdata_out   = bram_data_in;
    assign dbg_state_out    = state;
    assign dbg_cnt_out      = cnt;

endmodule
